// File: rtl/ppm_pkg.sv
// Shared definitions for the Mode-S PPM demodulator: FSM encoding,
// message lengths and the preamble pulse/gap check offsets in samples.
package ppm_pkg;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_pre  = 2'd1,
    st_data = 2'd2,
    st_done = 2'd3
  } ppm_state_t;

  localparam int short_len   = 56;
  localparam int long_len    = 112;
  localparam int df_len_bits = 5;

  // Pulse centres sit at 0.25, 1.25, 3.75 and 4.75 us into the preamble.
  function automatic logic [15:0] pulse_ofs(input int s, input int i);
    case (i)
      0:       return 16'(s / 4);
      1:       return 16'((5 * s) / 4);
      2:       return 16'((15 * s) / 4);
      default: return 16'((19 * s) / 4);
    endcase
  endfunction

  // Gap centres between and after the pulses that must read as low.
  function automatic logic [15:0] gap_ofs(input int s, input int i);
    case (i)
      0:       return 16'((3 * s) / 4);
      1:       return 16'((9 * s) / 4);
      2:       return 16'((11 * s) / 4);
      default: return 16'((23 * s) / 4);
    endcase
  endfunction

endpackage

// File: rtl/ppm_demod_if.sv
// Decoded-message bus: one-clock msg_valid qualifies msg_data/msg_long,
// which then hold until the next message; no backpressure.
interface ppm_demod_if;
  logic         msg_valid;
  logic         msg_long;
  logic [111:0] msg_data;

  modport master (output msg_valid, msg_long, msg_data);
  modport slave  (input  msg_valid, msg_long, msg_data);
endinterface

// File: rtl/ppm_half_integ.sv
// Integrates log magnitude over the two half-chips of one PPM bit and decides it.
// bit_val/bit_done are valid combinationally on the last sample (k = spu-1).
module ppm_half_integ
  import ppm_pkg::*;
#(
  parameter int width = 10,
  parameter int spu   = 20,
  parameter int acc_w = 14
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ena,
  input  logic                     active,
  input  logic [$clog2(spu)-1:0]   k,
  input  logic [width-1:0]         logmag,
  output logic                     bit_val,
  output logic                     bit_done
);

  localparam int kw   = $clog2(spu);
  localparam int half = spu / 2;
  localparam int aw1  = acc_w + 1;

  logic [acc_w-1:0] acc_a;
  logic [acc_w-1:0] acc_b;
  logic [acc_w:0]   b_total;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_a <= '0;
      acc_b <= '0;
    end else if (ena && active) begin
      if (k == '0) begin
        acc_a <= acc_w'(logmag);
        acc_b <= '0;
      end else if (k < kw'(half)) begin
        acc_a <= acc_a + acc_w'(logmag);
      end else begin
        acc_b <= acc_b + acc_w'(logmag);
      end
    end
  end

  // The final sample belongs to half B and is folded in before the compare.
  assign b_total  = {1'b0, acc_b} + aw1'(logmag);
  assign bit_val  = ({1'b0, acc_a} > b_total);
  assign bit_done = ena && active && (k == kw'(spu - 1));

endmodule

// File: rtl/ppm_demod.sv
// Validates the Mode-S preamble after a detector trigger, then PPM-demodulates 56/112 bits.
// msg_valid one clock after the last data sample; output bus has no backpressure.
module ppm_demod
  import ppm_pkg::*;
#(
  parameter int width = 10,
  parameter int spu   = 20,
  parameter int acc_w = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             trigger,
  input  logic             slice_data,
  input  logic [width-1:0] logmag_dly,
  output logic             trigger_clr,
  output logic             busy,
  output logic             pre_fail,
  ppm_demod_if.master      msg
);

  localparam int kw = $clog2(spu);

  ppm_state_t       state_q, state_d;
  logic [15:0]      n_q, n_d;
  logic [kw-1:0]    k_q, k_d;
  logic [6:0]       bit_q, bit_d;
  logic [111:0]     sreg_q, sreg_nx;
  logic             len_long_q, len_nx;
  logic             pre_fail_q, fail_d;
  logic [111:0]     msg_data_q;
  logic             msg_long_q;
  logic             chk_fail;
  logic             last_bit;
  logic             bit_val;
  logic             bit_done;

  ppm_half_integ #(.width(width), .spu(spu), .acc_w(acc_w)) u_integ (
    .clock    (clock),
    .reset    (reset),
    .ena      (ena),
    .active   (state_q == st_data),
    .k        (k_q),
    .logmag   (logmag_dly),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  always_comb begin
    chk_fail = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (n_q == pulse_ofs(spu, i) && !slice_data) chk_fail = 1'b1;
      if (n_q == gap_ofs(spu, i) && slice_data)    chk_fail = 1'b1;
    end
  end

  assign last_bit = (bit_q == 7'(long_len - 1)) ||
                    ((bit_q == 7'(short_len - 1)) && !len_long_q);

  // n_q holds the index of the sample currently presented while in PREAMBLE.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    bit_d   = bit_q;
    fail_d  = 1'b0;
    case (state_q)
      st_idle: begin
        if (ena && trigger) begin
          state_d = st_pre;
          n_d     = 16'd1;
        end
      end
      st_pre: begin
        if (ena) begin
          if (trigger) begin
            n_d = 16'd1;
          end else if (chk_fail) begin
            state_d = st_idle;
            n_d     = '0;
            fail_d  = 1'b1;
          end else if (n_q == 16'(8 * spu - 1)) begin
            state_d = st_data;
            n_d     = '0;
            k_d     = '0;
            bit_d   = '0;
          end else begin
            n_d = n_q + 16'd1;
          end
        end
      end
      st_data: begin
        if (ena) begin
          if (k_q == kw'(spu - 1)) begin
            k_d = '0;
            if (last_bit) state_d = st_done;
            else          bit_d   = bit_q + 7'd1;
          end else begin
            k_d = k_q + kw'(1);
          end
        end
      end
      st_done: begin
        state_d = st_idle;
        bit_d   = '0;
      end
      default: state_d = st_idle;
    endcase
  end

  always_comb begin
    sreg_nx = sreg_q;
    len_nx  = len_long_q;
    if (state_q == st_pre && state_d == st_data) begin
      sreg_nx = '0;
      len_nx  = 1'b0;
    end
    if (bit_done) sreg_nx[7'(long_len - 1) - bit_q] = bit_val;
    // DF >= 16 (first bit set) means a 112-bit frame.
    if (bit_done && bit_q == 7'(df_len_bits - 1)) len_nx = sreg_q[long_len - 1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= st_idle;
      n_q        <= '0;
      k_q        <= '0;
      bit_q      <= '0;
      sreg_q     <= '0;
      len_long_q <= 1'b0;
      pre_fail_q <= 1'b0;
      msg_data_q <= '0;
      msg_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      bit_q      <= bit_d;
      sreg_q     <= sreg_nx;
      len_long_q <= len_nx;
      pre_fail_q <= fail_d;
      if (state_q == st_data && state_d == st_done) begin
        msg_data_q <= sreg_nx;
        msg_long_q <= len_long_q;
      end
    end
  end

  assign busy          = (state_q == st_pre) || (state_q == st_data);
  assign pre_fail      = pre_fail_q;
  assign trigger_clr   = (state_q == st_done) || pre_fail_q;
  assign msg.msg_valid = (state_q == st_done);
  assign msg.msg_long  = msg_long_q;
  assign msg.msg_data  = msg_data_q;

endmodule

// File: tb/tb_ppm_demod.sv
// Directed bench for ppm_demod: table of full frames plus hand-built
// preamble-failure, retrigger and async-reset sequences.
module tb_ppm_demod;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       trigger = 1'b0;
  logic       slice_data = 1'b0;
  logic [9:0] logmag_dly = '0;
  logic       trigger_clr, busy, pre_fail;

  ppm_demod_if mif ();

  ppm_demod dut (
    .clock       (clock),
    .reset       (reset),
    .ena         (ena),
    .trigger     (trigger),
    .slice_data  (slice_data),
    .logmag_dly  (logmag_dly),
    .trigger_clr (trigger_clr),
    .busy        (busy),
    .pre_fail    (pre_fail),
    .msg         (mif)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  int cur_n = 0;
  int capt_n = 0;
  int n_valid, n_clr, n_fail, valid_n, fail_n;
  logic [111:0] got_data;
  logic         got_long;

  localparam logic [111:0] long_pat  = 112'h8D4840D6202CC371C32CE0576098;
  localparam logic [111:0] tie_pat   = 112'h8D4848D6202CC371C32CE0576098;
  localparam logic [111:0] short_pat = {56'h5D4840D6D0A3F1, 56'h0};

  typedef struct {
    logic [111:0] pat;
    int           nbits;
    int           div;
    int           tie;
    logic         exp_long;
    logic [111:0] exp_data;
    int           exp_n;
  } vec_t;

  vec_t vt[5];

  always @(posedge clock) if (ena) capt_n = cur_n;

  always @(negedge clock) begin
    if (mif.msg_valid) begin
      n_valid++;
      valid_n  = capt_n;
      got_data = mif.msg_data;
      got_long = mif.msg_long;
    end
    if (trigger_clr) n_clr++;
    if (pre_fail) begin
      n_fail++;
      fail_n = capt_n;
    end
  end

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_valid = 0; n_clr = 0; n_fail = 0; valid_n = -1; fail_n = -1;
    got_data = '0; got_long = 1'b0;
  endtask

  function automatic logic pre_bit(input int n);
    return (n < 10) || (n >= 20 && n < 30) || (n >= 70 && n < 80) || (n >= 90 && n < 100);
  endfunction

  // One ena sample, followed by div-1 clocks with ena low.
  task automatic drive_samp(input logic trig, input logic sd, input int lm, input int div);
    @(posedge clock); #1;
    ena = 1'b1; trigger = trig; slice_data = sd; logmag_dly = 10'(lm);
    if (trig) cur_n = 0; else cur_n++;
    for (int i = 1; i < div; i++) begin
      @(posedge clock); #1;
      ena = 1'b0; trigger = 1'b0;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive_samp(1'b0, 1'b0, 50, 1);
    @(posedge clock); #1;
    ena = 1'b0;
  endtask

  task automatic send_frame(input logic [111:0] pat, input int nbits, input int div,
                            input int tie_bit, input int bad_n, input int abort_n);
    logic p;
    int lm;
    for (int n = 0; n < 160; n++) begin
      p = pre_bit(n);
      if (n == bad_n) p = ~p;
      drive_samp(n == 0, p, p ? 400 : 50, div);
    end
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < 20; k++) begin
        if (b == tie_bit) lm = 200;
        else lm = ((k < 10) == pat[111 - b]) ? 400 : 50;
        drive_samp(1'b0, lm == 400, lm, div);
        if (160 + b * 20 + k == abort_n) begin
          @(negedge clock);
          reset = 1'b0;
          #1;
          chk("rst_busy", 112'(busy), 112'd0);
          chk("rst_valid", 112'(mif.msg_valid), 112'd0);
          chk("rst_clr", 112'(trigger_clr), 112'd0);
          chk("rst_data", mif.msg_data, 112'd0);
          ena = 1'b0;
          repeat (3) @(posedge clock);
          @(negedge clock);
          reset = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    vt[0] = '{long_pat,  112, 1, -1, 1'b1, long_pat,  2399};
    vt[1] = '{short_pat,  56, 1, -1, 1'b0, short_pat, 1279};
    vt[2] = '{tie_pat,   112, 1, 20, 1'b1, long_pat,  2399};
    vt[3] = '{tie_pat,   112, 3, 20, 1'b1, long_pat,  2399};
    vt[4] = '{short_pat,  56, 3, -1, 1'b0, short_pat, 1279};

    clr_mon();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 112'(busy), 112'd0);
    chk("reset_clr", 112'(trigger_clr), 112'd0);
    chk("reset_fail", 112'(pre_fail), 112'd0);
    chk("reset_valid", 112'(mif.msg_valid), 112'd0);
    chk("reset_long", 112'(mif.msg_long), 112'd0);
    chk("reset_data", mif.msg_data, 112'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(3);

    for (int v = 0; v < 5; v++) begin
      clr_mon();
      send_frame(vt[v].pat, vt[v].nbits, vt[v].div, vt[v].tie, -1, -1);
      idle(5);
      chk($sformatf("v%0d_valid_cnt", v), 112'(n_valid), 112'd1);
      chk($sformatf("v%0d_clr_cnt", v), 112'(n_clr), 112'd1);
      chk($sformatf("v%0d_fail_cnt", v), 112'(n_fail), 112'd0);
      chk($sformatf("v%0d_valid_n", v), 112'(valid_n), 112'(vt[v].exp_n));
      chk($sformatf("v%0d_long", v), 112'(got_long), 112'(vt[v].exp_long));
      chk($sformatf("v%0d_data", v), got_data, vt[v].exp_data);
      chk($sformatf("v%0d_busy", v), 112'(busy), 112'd0);
    end

    // Preamble failure: a gap centre (n=45) reads high.
    clr_mon();
    send_frame(long_pat, 112, 1, -1, 45, -1);
    idle(3);
    chk("pf_fail_cnt", 112'(n_fail), 112'd1);
    chk("pf_fail_n", 112'(fail_n), 112'd45);
    chk("pf_clr_cnt", 112'(n_clr), 112'd1);
    chk("pf_valid_cnt", 112'(n_valid), 112'd0);
    chk("pf_busy", 112'(busy), 112'd0);

    // Retrigger at n=30 of a first preamble; decode timed from the second trigger.
    clr_mon();
    for (int n = 0; n < 30; n++) drive_samp(n == 0, pre_bit(n), pre_bit(n) ? 400 : 50, 1);
    send_frame(short_pat, 56, 1, -1, -1, -1);
    idle(5);
    chk("rt_valid_cnt", 112'(n_valid), 112'd1);
    chk("rt_valid_n", 112'(valid_n), 112'd1279);
    chk("rt_fail_cnt", 112'(n_fail), 112'd0);
    chk("rt_data", got_data, short_pat);
    chk("rt_long", 112'(got_long), 112'd0);

    // Async reset during data bit 60 of a long frame, then a clean frame.
    clr_mon();
    send_frame(long_pat, 112, 1, -1, -1, 160 + 60 * 20);
    idle(5);
    chk("ar_busy", 112'(busy), 112'd0);
    chk("ar_valid_cnt", 112'(n_valid), 112'd0);
    chk("ar_clr_cnt", 112'(n_clr), 112'd0);
    clr_mon();
    send_frame(short_pat, 56, 1, -1, -1, -1);
    idle(5);
    chk("ar2_valid_cnt", 112'(n_valid), 112'd1);
    chk("ar2_valid_n", 112'(valid_n), 112'd1279);
    chk("ar2_data", got_data, short_pat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
